// File: rtl/dest_sink.sv
// -----------------------------------------------------------------------------
// dest_sink
//   Receive-side endpoint of the arqui datapath. Drains the two destination
//   FIFOs (D0, D1) for the downstream consumer using round-robin pops,
//   registers every popped word with its source tag, counts words per
//   destination and raises a sticky flag when a word arrives through the
//   FIFO that does not match its destination bit.
//
//   Optional build macro:
//     COUNT_SAT_EN  - when defined, count_d0/count_d1 saturate at all-ones;
//                     when undefined they wrap to zero.
//
//   Ports:
//     clk        system clock, all logic on posedge
//     reset_L    synchronous reset, active low
//     init       synchronous clear of counters/flags
//     enable     consumer ready; pops only issued while high
//     empty_D0/1 FIFO empty flags
//     data_out0/1 FIFO read data, valid the cycle after the pop
//     pop_d0/1   pop requests (combinational)
//     data_rx    last received word
//     valid_rx   one-cycle pulse when data_rx/src_rx update
//     src_rx     source of data_rx (0 = D0, 1 = D1)
//     count_d0/1 words received per destination
//     route_err  sticky misroute flag
//     idle_rx    high while the controller is in IDLE
// -----------------------------------------------------------------------------
module dest_sink #(
   parameter int DATA_W   = 6,
   parameter int CNT_W    = 8,
   parameter int DEST_BIT = 4
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic              init,
   input  logic              enable,
   input  logic              empty_D0,
   input  logic              empty_D1,
   input  logic [DATA_W-1:0] data_out0,
   input  logic [DATA_W-1:0] data_out1,
   output logic              pop_d0,
   output logic              pop_d1,
   output logic [DATA_W-1:0] data_rx,
   output logic              valid_rx,
   output logic              src_rx,
   output logic [CNT_W-1:0]  count_d0,
   output logic [CNT_W-1:0]  count_d1,
   output logic              route_err,
   output logic              idle_rx
);

   typedef enum logic [1:0] {
      ST_RESET  = 2'd0,
      ST_INIT   = 2'd1,
      ST_IDLE   = 2'd2,
      ST_ACTIVE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic                rr_last_q;
   logic                pend_d0_q, pend_d1_q;
   logic [DATA_W-1:0]   data_rx_q;
   logic                valid_rx_q;
   logic                src_rx_q;
   logic [CNT_W-1:0]    count_d0_q, count_d1_q;
   logic                route_err_q;
   logic                idle_rx_q;

   logic                cap_vld_s;
   logic                cap_src_s;
   logic [DATA_W-1:0]   cap_word_s;
   logic                misroute_s;

   // Counter step: wraps by default, holds at all-ones when saturation is built in.
   function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
`ifdef COUNT_SAT_EN
      if (c == {CNT_W{1'b1}}) begin
         cnt_inc = c;
      end else begin
         cnt_inc = c + 1'b1;
      end
`else
      cnt_inc = c + 1'b1;
`endif
   endfunction

   // Pop arbitration: single pop per cycle, alternate on contention.
   always_comb begin
      pop_d0 = 1'b0;
      pop_d1 = 1'b0;
      if ((state_q == ST_IDLE || state_q == ST_ACTIVE) && enable) begin
         if (!empty_D0 && !empty_D1) begin
            // rr_last holds the last served FIFO; serve the other one.
            if (rr_last_q) begin
               pop_d0 = 1'b1;
            end else begin
               pop_d1 = 1'b1;
            end
         end else if (!empty_D0) begin
            pop_d0 = 1'b1;
         end else if (!empty_D1) begin
            pop_d1 = 1'b1;
         end else begin
            pop_d0 = 1'b0;
         end
      end else begin
         pop_d0 = 1'b0;
      end
   end

   // Capture path: FIFO data is valid the cycle after its pop.
   always_comb begin
      cap_vld_s  = pend_d0_q | pend_d1_q;
      cap_src_s  = pend_d1_q;
      cap_word_s = pend_d1_q ? data_out1 : data_out0;
      misroute_s = cap_word_s[DEST_BIT] != cap_src_s;
   end

   // Next-state logic; init overrides every state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RESET:  state_d = ST_IDLE;
         ST_INIT:   state_d = ST_IDLE;
         ST_IDLE: begin
            if (enable && (!empty_D0 || !empty_D1)) begin
               state_d = ST_ACTIVE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            if (empty_D0 && empty_D1 && !pend_d0_q && !pend_d1_q &&
                !pop_d0 && !pop_d1) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_ACTIVE;
            end
         end
         default:   state_d = ST_RESET;
      endcase
      if (init) begin
         state_d = ST_INIT;
      end else begin
         state_d = state_d;
      end
   end

   // State, arbitration history, pending flags and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset_L) begin
         state_q     <= ST_RESET;
         rr_last_q   <= 1'b1;
         pend_d0_q   <= 1'b0;
         pend_d1_q   <= 1'b0;
         data_rx_q   <= '0;
         valid_rx_q  <= 1'b0;
         src_rx_q    <= 1'b0;
         count_d0_q  <= '0;
         count_d1_q  <= '0;
         route_err_q <= 1'b0;
         idle_rx_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         idle_rx_q <= (state_d == ST_IDLE);
         if (pop_d0) begin
            rr_last_q <= 1'b0;
         end else if (pop_d1) begin
            rr_last_q <= 1'b1;
         end
         if (init) begin
            pend_d0_q   <= 1'b0;
            pend_d1_q   <= 1'b0;
            valid_rx_q  <= 1'b0;
            count_d0_q  <= '0;
            count_d1_q  <= '0;
            route_err_q <= 1'b0;
         end else begin
            pend_d0_q  <= pop_d0;
            pend_d1_q  <= pop_d1;
            valid_rx_q <= cap_vld_s;
            if (cap_vld_s) begin
               data_rx_q <= cap_word_s;
               src_rx_q  <= cap_src_s;
               if (cap_src_s) begin
                  count_d1_q <= cnt_inc(count_d1_q);
               end else begin
                  count_d0_q <= cnt_inc(count_d0_q);
               end
               if (misroute_s) begin
                  route_err_q <= 1'b1;
               end
            end
         end
      end
   end

   assign data_rx   = data_rx_q;
   assign valid_rx  = valid_rx_q;
   assign src_rx    = src_rx_q;
   assign count_d0  = count_d0_q;
   assign count_d1  = count_d1_q;
   assign route_err = route_err_q;
   assign idle_rx   = idle_rx_q;

endmodule

// File: doc/dest_sink.md
Name: dest_sink

Overview:
Receive-side endpoint of the arqui datapath: drains the two destination FIFOs (D0, D1) on behalf of the downstream consumer.
- Issues pop_d0/pop_d1 under round-robin arbitration.
- Registers each popped word together with its source tag.
- Counts words per destination and flags misrouted words.
- Pairs with the push-side source: that side fills the main FIFO, this block is the reader at the far end.

Parameters:
DATA_W, 6, word width of data_out0/data_out1
CNT_W, 8, width of per-destination word counters
DEST_BIT, 4, index of the bit in each word carrying its destination id (0 = D0, 1 = D1)

Ports:
clk  input  1  single system clock, all logic on posedge
reset_L  input  1  synchronous reset, active low
init  input  1  synchronous clear of counters/flags (same cycle as arqui init)
enable  input  1  consumer ready; pops only issued while high
empty_D0  input  1  D0 FIFO empty
empty_D1  input  1  D1 FIFO empty
data_out0  input  DATA_W  D0 FIFO read data, valid the cycle after pop_d0
data_out1  input  DATA_W  D1 FIFO read data, valid the cycle after pop_d1
pop_d0  output  1  pop request to D0 FIFO
pop_d1  output  1  pop request to D1 FIFO
data_rx  output  DATA_W  last received word
valid_rx  output  1  data_rx/src_rx updated this cycle (one-cycle pulse)
src_rx  output  1  source of data_rx (0 = D0, 1 = D1)
count_d0  output  CNT_W  words received from D0
count_d1  output  CNT_W  words received from D1
route_err  output  1  sticky: word's DEST_BIT mismatched its source FIFO
idle_rx  output  1  high in IDLE state

Behaviour:
- Reset: reset_L low at a posedge forces state RESET; all outputs 0; rr_last = 1, so D0 wins the first tie; pending flags cleared. Reset mid-transfer discards any pending word: no valid_rx afterwards.
- FSM states: RESET, INIT, IDLE, ACTIVE.
  - RESET -> IDLE on the first edge with reset_L high.
  - Any state -> INIT when init = 1; INIT -> IDLE when init = 0.
  - IDLE -> ACTIVE when enable & (!empty_D0 | !empty_D1).
  - ACTIVE -> IDLE when both FIFOs are empty, no pending word, and no pop this cycle.
  - ACTIVE stays ACTIVE when enable drops; only pops stop.
- INIT clears counters, route_err, valid_rx and pending flags; no pops during INIT or RESET.
- Pop generation:
  - Combinational from registered state/rr_last plus current empty flags.
  - Pops are issued only when state is IDLE or ACTIVE and enable = 1.
  - At most one pop per cycle.
  - If only one FIFO is non-empty, pop it.
  - If both are non-empty, pop the one != rr_last.
  - rr_last updates to the popped FIFO at the edge.
  - pop is never asserted on an empty FIFO.
- Latency:
  - pop_dX high in cycle k sets pend_X at the edge ending k.
  - In cycle k+1 data_outX is sampled; at the edge ending k+1, data_rx <= data_outX, src_rx <= X, valid_rx <= 1.
  - Total: pop to valid_rx = 2 cycles.
  - Back-to-back pops give back-to-back valid_rx; sustained 1 word/cycle.
- Counters: count_dX increments at the same edge that registers the word. Wrap at 2^CNT_W unless COUNT_SAT_EN is defined.
- Routing check: route_err sets when data_outX[DEST_BIT] != X at capture. Clears only by reset or init.
- idle_rx = (state == IDLE); registered.

Optional Feature:
COUNT_SAT_EN
- Defined: count_d0/count_d1 saturate at 2^CNT_W-1 and hold.
- Undefined: counters wrap to 0 after 2^CNT_W-1.

Test Plan:
1. Reset: hold reset_L = 0 for 2 clocks, FIFOs non-empty -> pops, valid_rx, counts, route_err all 0; idle_rx = 1 one edge after release.
2. Single source: D0 holds 3 words (0x00, 0x01, 0x02), D1 empty, enable = 1 -> pop_d0 high 3 consecutive cycles; valid_rx pulses 2 cycles after each pop; data_rx = 0x00, 0x01, 0x02; src_rx = 0; count_d0 = 3; route_err = 0.
3. Round-robin: both FIFOs non-empty for 4 cycles -> pop sequence D0, D1, D0, D1; count_d0 = count_d1 = 2.
4. Misroute: D0 delivers 0x12 (bit4 = 1) -> route_err = 1 at capture and stays 1 until init pulse; count_d0 still increments.
5. Stall and init: enable = 0 mid-stream -> pops stop immediately; the in-flight word still produces valid_rx. init pulse -> counters = 0, state INIT, no pops, then IDLE.
6. Overflow: 256 D1 words -> count_d1 = 0 without COUNT_SAT_EN, 255 with it.
